// File: rtl/song_pkg.sv
// Shared definitions for the multi-song note sequencer: ROM entry layout,
// song start addresses, rest code and FSM state encoding.
package song_pkg;

    localparam int NOTE_W_DEF = 5;
    localparam int DUR_W_DEF  = 4;
    localparam int ADDR_W_DEF = 8;

    // Note code that silences the tone stage.
    localparam logic [NOTE_W_DEF-1:0] REST_NOTE_DEF = 5'd21;

    // One ROM word; dur == 0 marks the end of a song.
    typedef struct packed {
        logic [NOTE_W_DEF-1:0] note;
        logic [DUR_W_DEF-1:0]  dur;
    } song_entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_END   = 3'd4
    } song_state_e;

    // Plain-vector views of the state encoding for the state register.
    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_FETCH = S_FETCH;
    localparam logic [2:0] ST_PLAY  = S_PLAY;
    localparam logic [2:0] ST_PAUSE = S_PAUSE;
    localparam logic [2:0] ST_END   = S_END;

    // First ROM address of each selectable song.
    function automatic logic [ADDR_W_DEF-1:0] song_base(input logic [31:0] idx);
        case (idx)
            32'd0:   return 8'd0;
            32'd1:   return 8'd16;
            32'd2:   return 8'd32;
            32'd3:   return 8'd48;
            default: return 8'd0;
        endcase
    endfunction

    function automatic song_entry_t mk_entry(input logic [NOTE_W_DEF-1:0] note,
                                             input logic [DUR_W_DEF-1:0]  dur);
        song_entry_t e;
        e.note = note;
        e.dur  = dur;
        return e;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control and note-bus bundle between the front panel / tone stage and the sequencer.
interface song_sequencer_if import song_pkg::*; #(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int SEL_W  = 2
);
    logic              play;
    logic              stop;
    logic              loop_en;
    logic [SEL_W-1:0]  song_sel;
    logic [15:0]       tempo_div;
    logic [NOTE_W-1:0] song_data;
    logic              busy;
    logic              beat;
    logic              done;

    modport master (
        output play, stop, loop_en, song_sel, tempo_div,
        input  song_data, busy, beat, done
    );

    modport slave (
        input  play, stop, loop_en, song_sel, tempo_div,
        output song_data, busy, beat, done
    );
endinterface

// File: rtl/song_rom.sv
// Song ROM: synchronous read, one cycle from addr to entry.
module song_rom import song_pkg::*; #(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int DUR_W  = DUR_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       addr,
    output logic [NOTE_W+DUR_W-1:0] entry
);

    song_entry_t e_s;

    // Song contents; unlisted addresses read as an end-of-song marker.
    always_comb begin
        case (addr)
            ADDR_W'(0):  e_s = mk_entry(5'd12, 4'd2);
            ADDR_W'(1):  e_s = mk_entry(5'd9,  4'd1);
            ADDR_W'(2):  e_s = mk_entry(REST_NOTE_DEF, 4'd0);
            ADDR_W'(16): e_s = mk_entry(5'd7,  4'd3);
            ADDR_W'(17): e_s = mk_entry(5'd5,  4'd1);
            ADDR_W'(18): e_s = mk_entry(REST_NOTE_DEF, 4'd0);
            ADDR_W'(32): e_s = mk_entry(5'd3,  4'd1);
            ADDR_W'(33): e_s = mk_entry(REST_NOTE_DEF, 4'd1);
            ADDR_W'(34): e_s = mk_entry(5'd3,  4'd2);
            ADDR_W'(35): e_s = mk_entry(REST_NOTE_DEF, 4'd0);
            ADDR_W'(48): e_s = mk_entry(5'd1,  4'd4);
            ADDR_W'(49): e_s = mk_entry(REST_NOTE_DEF, 4'd0);
            default:     e_s = mk_entry(REST_NOTE_DEF, 4'd0);
        endcase
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else begin
            entry <= {NOTE_W'(e_s.note), DUR_W'(e_s.dur)};
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Multi-song note sequencer: plays {note, dur} entries from song_rom at a
// programmable tempo with pause/resume, stop, end detection and looping.
module song_sequencer import song_pkg::*; #(
    parameter int NOTE_W    = NOTE_W_DEF,
    parameter int DUR_W     = DUR_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_SONGS = 4,
    parameter int REST_NOTE = 21
) (
    input logic              clk,
    input logic              rst_n,
    song_sequencer_if.slave  io
);

    localparam int SEL_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
    localparam logic [NOTE_W-1:0] REST_CODE = NOTE_W'(REST_NOTE);

    logic [2:0]              state_r, state_d, ret_r, ret_d;
    logic [ADDR_W-1:0]       addr_r, addr_d;
    logic [SEL_W-1:0]        sel_r, sel_d;
    logic [NOTE_W-1:0]       note_r, note_d, data_r, data_d;
    logic [DUR_W-1:0]        dur_r, dur_d;
    logic [15:0]             tick_r, tick_d, period_m1_s;
    logic                    beat_r, beat_d, done_r, done_d, busy_r, busy_d;
    logic                    tick_s;
    logic [NOTE_W+DUR_W-1:0] rom_q_s;
    logic [NOTE_W-1:0]       rom_note_s;
    logic [DUR_W-1:0]        rom_dur_s;

    // The ROM is addressed with the next address so its output is valid in
    // the cycle after the address is chosen (the FETCH cycle, or the prefetch
    // during PLAY).
    song_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr_d),
        .entry (rom_q_s)
    );

    assign rom_note_s  = rom_q_s[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur_s   = rom_q_s[DUR_W-1:0];
    assign period_m1_s = (io.tempo_div == 16'd0) ? 16'd0 : io.tempo_div - 16'd1;
    assign tick_s      = (tick_r >= period_m1_s);

    // Next-state and datapath decisions; stop overrides everything.
    always_comb begin
        state_d = state_r;
        ret_d   = ret_r;
        addr_d  = addr_r;
        sel_d   = sel_r;
        note_d  = note_r;
        dur_d   = dur_r;
        tick_d  = tick_r;
        data_d  = data_r;
        if (io.stop) begin
            state_d = ST_IDLE;
            data_d  = REST_CODE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_d = REST_CODE;
                    if (io.play) begin
                        sel_d   = io.song_sel;
                        addr_d  = ADDR_W'(song_base(32'(io.song_sel)));
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (!io.play) begin
                        state_d = ST_PAUSE;
                        ret_d   = ST_FETCH;
                        data_d  = REST_CODE;
                    end else if (rom_dur_s == '0) begin
                        state_d = ST_END;
                        data_d  = REST_CODE;
                    end else begin
                        state_d = ST_PLAY;
                        note_d  = rom_note_s;
                        data_d  = rom_note_s;
                        dur_d   = rom_dur_s;
                        tick_d  = 16'd0;
                        addr_d  = addr_r + ADDR_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (!io.play) begin
                        // The cycle just shown counts toward the note, but a
                        // pending tick is held so it fires after resume.
                        state_d = ST_PAUSE;
                        ret_d   = ST_PLAY;
                        data_d  = REST_CODE;
                        if (tick_s) begin
                            tick_d = tick_r;
                        end else begin
                            tick_d = tick_r + 16'd1;
                        end
                    end else if (!tick_s) begin
                        tick_d = tick_r + 16'd1;
                    end else if (dur_r != DUR_W'(1)) begin
                        tick_d = 16'd0;
                        dur_d  = dur_r - DUR_W'(1);
                    end else if (rom_dur_s == '0) begin
                        tick_d  = 16'd0;
                        state_d = ST_END;
                        data_d  = REST_CODE;
                    end else begin
                        tick_d = 16'd0;
                        note_d = rom_note_s;
                        data_d = rom_note_s;
                        dur_d  = rom_dur_s;
                        addr_d = addr_r + ADDR_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (io.play) begin
                        state_d = ret_r;
                        if (ret_r == ST_PLAY) begin
                            data_d = note_r;
                        end else begin
                            data_d = REST_CODE;
                        end
                    end else begin
                        data_d = REST_CODE;
                    end
                end
                ST_END: begin
                    data_d = REST_CODE;
                    if (io.loop_en) begin
                        addr_d  = ADDR_W'(song_base(32'(sel_r)));
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = REST_CODE;
                end
            endcase
        end
    end

    // Status flags aligned with the state they describe: beat marks the PLAY
    // cycle in which the tick happens, done marks the END cycle.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        beat_d = (state_d == ST_PLAY) && (tick_d >= period_m1_s);
        done_d = (state_d == ST_END);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ret_r   <= ST_IDLE;
            addr_r  <= '0;
            sel_r   <= '0;
            note_r  <= '0;
            dur_r   <= '0;
            tick_r  <= 16'd0;
            data_r  <= REST_CODE;
            beat_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_d;
            ret_r   <= ret_d;
            addr_r  <= addr_d;
            sel_r   <= sel_d;
            note_r  <= note_d;
            dur_r   <= dur_d;
            tick_r  <= tick_d;
            data_r  <= data_d;
            beat_r  <= beat_d;
            done_r  <= done_d;
            busy_r  <= busy_d;
        end
    end

    assign io.song_data = data_r;
    assign io.busy      = busy_r;
    assign io.beat      = beat_r;
    assign io.done      = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: one-shot, loop, pause/resume, stop,
// tempo_div=0 and asynchronous reset mid-note.
module tb_song_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    int   failed;

    song_sequencer_if #(.NOTE_W(5), .SEL_W(2)) io ();

    song_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expect `note` on the bus for n consecutive cycles with `beats` beat pulses.
    task automatic run_note(input string tag, input logic [31:0] note, input int n, input int beats);
        int b;
        int d;
        b = 0;
        d = 0;
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(io.song_data), note);
            if (io.beat) b++;
            if (io.done) d++;
            step();
        end
        chk({tag, "_beats"}, 32'(b), 32'(beats));
        chk({tag, "_done"}, 32'(d), 32'd0);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        failed = 0;
        rst_n        = 1'b0;
        io.play      = 1'b0;
        io.stop      = 1'b0;
        io.loop_en   = 1'b0;
        io.song_sel  = 2'd0;
        io.tempo_div = 16'd4;
        repeat (3) step();

        // Reset values
        chk("rst_data", 32'(io.song_data), 32'd21);
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_beat", 32'(io.beat), 32'd0);
        chk("rst_done", 32'(io.done), 32'd0);
        rst_n = 1'b1;

        // Idle with play low
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_data", 32'(io.song_data), 32'd21);
            chk("idle_busy", 32'(io.busy), 32'd0);
        end

        // One-shot song 0 at tempo 4
        io.play = 1'b1;
        step();
        chk("t1_fetch_data", 32'(io.song_data), 32'd21);
        chk("t1_fetch_busy", 32'(io.busy), 32'd1);
        step();
        run_note("t1_n12", 32'd12, 8, 2);
        run_note("t1_n9", 32'd9, 4, 1);
        chk("t1_end_data", 32'(io.song_data), 32'd21);
        chk("t1_end_done", 32'(io.done), 32'd1);
        io.play = 1'b0;
        step();
        chk("t1_idle_busy", 32'(io.busy), 32'd0);
        chk("t1_idle_done", 32'(io.done), 32'd0);
        chk("t1_idle_data", 32'(io.song_data), 32'd21);

        // Looped playback: two REST cycles between passes
        io.loop_en = 1'b1;
        io.play    = 1'b1;
        step();
        step();
        run_note("t2_n12", 32'd12, 8, 2);
        run_note("t2_n9", 32'd9, 4, 1);
        chk("t2_end_data", 32'(io.song_data), 32'd21);
        chk("t2_end_done", 32'(io.done), 32'd1);
        step();
        chk("t2_fetch_data", 32'(io.song_data), 32'd21);
        chk("t2_fetch_done", 32'(io.done), 32'd0);
        chk("t2_fetch_busy", 32'(io.busy), 32'd1);
        step();
        io.loop_en = 1'b0;

        // Pause after 3 cycles of note 12, hold 10 cycles, resume
        run_note("t3_pre", 32'd12, 2, 0);
        chk("t3_c3", 32'(io.song_data), 32'd12);
        io.play = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t3_pause_data", 32'(io.song_data), 32'd21);
            chk("t3_pause_busy", 32'(io.busy), 32'd1);
            if (i == 9) io.play = 1'b1;
            step();
        end
        run_note("t3_rest12", 32'd12, 5, 2);
        run_note("t3_n9", 32'd9, 4, 1);
        chk("t3_end_done", 32'(io.done), 32'd1);
        io.play = 1'b0;
        step();
        chk("t3_idle_busy", 32'(io.busy), 32'd0);

        // Stop mid-note, then restart from the first entry
        io.play = 1'b1;
        step();
        step();
        run_note("t4_pre", 32'd12, 2, 0);
        io.stop = 1'b1;
        step();
        chk("t4_stop_data", 32'(io.song_data), 32'd21);
        chk("t4_stop_busy", 32'(io.busy), 32'd0);
        chk("t4_stop_done", 32'(io.done), 32'd0);
        step();
        chk("t4_hold_busy", 32'(io.busy), 32'd0);
        chk("t4_hold_done", 32'(io.done), 32'd0);
        io.stop = 1'b0;
        step();
        chk("t4_fetch_busy", 32'(io.busy), 32'd1);
        step();
        chk("t4_restart", 32'(io.song_data), 32'd12);
        io.play = 1'b0;
        io.stop = 1'b1;
        step();
        io.stop = 1'b0;
        step();
        chk("t4_clean_busy", 32'(io.busy), 32'd0);

        // tempo_div = 0 behaves as one cycle per beat (song 1)
        io.tempo_div = 16'd0;
        io.song_sel  = 2'd1;
        io.play      = 1'b1;
        step();
        step();
        run_note("t5_n7", 32'd7, 3, 3);
        run_note("t5_n5", 32'd5, 1, 1);
        chk("t5_end_done", 32'(io.done), 32'd1);
        io.play = 1'b0;
        step();
        chk("t5_idle_busy", 32'(io.busy), 32'd0);

        // Asynchronous reset mid-note
        io.play = 1'b1;
        step();
        step();
        chk("t6_note", 32'(io.song_data), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_data", 32'(io.song_data), 32'd21);
        chk("t6_async_busy", 32'(io.busy), 32'd0);
        io.play = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        chk("t6_after_data", 32'(io.song_data), 32'd21);
        chk("t6_after_busy", 32'(io.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Parametrised multi-song note sequencer that drives the note-code bus feeding the tone generator. It is the next generation of the fixed-length per-song player: one block holds several songs in a shared ROM of {note, duration} entries and plays them at a programmable tempo. It adds pause/resume, explicit stop, end-of-song detection, and selectable one-shot or looped playback. It sits between the front-panel controls and the frequency-divider/tone stage.

## Interface
Parameters:
- NOTE_W, 5, note-code width
- DUR_W, 4, duration field width, in beats
- ADDR_W, 8, song ROM address width
- NUM_SONGS, 4, number of selectable songs
- REST_NOTE, 21, note code meaning silence

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- play  in  1  level; 1 = play or resume, 0 = pause
- stop  in  1  level; forces return to idle, priority over play
- loop_en  in  1  1 = restart the song at its end, 0 = one-shot
- song_sel  in  $clog2(NUM_SONGS)  song index; sampled only when leaving IDLE
- tempo_div  in  16  clk cycles per beat; 0 is treated as 1
- song_data  out  NOTE_W  registered note code to the tone stage
- busy  out  1  high in any state other than IDLE
- beat  out  1  one-cycle pulse on each beat tick while in PLAY
- done  out  1  one-cycle pulse when the end-of-song marker is reached

## Operation
- ROM entry format: {note[NOTE_W], dur[DUR_W]}.
  - dur == 0 is the end-of-song marker.
  - Each song starts at SONG_BASE[song_sel].
- FSM states: IDLE, FETCH, PLAY, PAUSE, END.
- IDLE:
  - song_data = REST_NOTE.
  - On play=1 and stop=0: latch song_sel, set addr = base, go to FETCH.
- FETCH: one cycle for the registered ROM read. Next cycle:
  - dur == 0: go to END.
  - Otherwise: load note into song_data, load dur_cnt = dur, clear tick_cnt, issue addr+1 (prefetch), go to PLAY.
- PLAY:
  - tick_cnt counts 0 to T-1, where T = max(tempo_div, 1). At T-1 it wraps, pulses beat and decrements dur_cnt.
  - When dur_cnt == 1 and a tick occurs, the prefetched entry is consumed in the same cycle:
    - dur == 0: go to END.
    - Otherwise: load note and dur, addr+1, stay in PLAY.
  - Each note therefore lasts exactly dur*T cycles, with no gap between notes.
- END:
  - Lasts one cycle; done=1, song_data = REST_NOTE.
  - loop_en=1: set addr = base of the latched song, go to FETCH.
  - loop_en=0: go to IDLE.
- PAUSE (play=0 while in FETCH or PLAY):
  - song_data = REST_NOTE; tick_cnt, dur_cnt, addr and current note are frozen.
  - The return state is recorded.
  - On play=1, go back to the return state. The current note is re-driven on the same edge, and the remaining duration continues exactly where it stopped.
- stop=1 in any state: go to IDLE on the next edge, song_data = REST_NOTE, no done pulse.
- addr wraps modulo 2^ADDR_W. tempo_div changes take effect at the next tick_cnt wrap comparison.

## Timing
- Reset values: state IDLE, song_data = REST_NOTE, busy=0, beat=0, done=0, all counters 0.
- Latency:
  - play rise in IDLE to first note on song_data: 2 clk edges.
  - play fall to REST on song_data: 1 edge.
  - Resume to note on song_data: 1 edge.
- Loop wrap: the last note is followed by REST for exactly 2 cycles (END, FETCH), then the first note.
- Simultaneous events:
  - stop beats play.
  - play=0 on the same cycle as a note-end tick: PAUSE wins. The tick is not consumed.
  - loop_en is sampled in END.
- rst_n asserted mid-song: all outputs return to reset values immediately (asynchronously).

## Structure
- Package song_pkg holds:
  - REST_NOTE default
  - the entry typedef {note, dur}
  - the SONG_BASE address table
  - the FSM state enum
- Sub-module song_rom: synchronous ROM, addr in, registered entry out, one-cycle latency. Song contents live there as a case table.

## Test plan
- Reset, then idle with play=0 -> song_data=21, busy=0 indefinitely.
- tempo_div=4, song 0 = {12,2},{9,1},{x,0}; play=1 -> 12 for 8 cycles, then 9 for 4 cycles, then done pulse and REST. Check 2 beat pulses during 12 and 1 during 9.
- Same song with loop_en=1 -> after 9: exactly 2 REST cycles, then 12 again. done pulses once per pass.
- Pause after 3 of the 8 cycles of note 12, hold 10 cycles, resume -> REST for 10 cycles, then 12 for the remaining 5 cycles.
- stop=1 mid-note with play=1 -> next edge song_data=21, busy=0, no done pulse. Releasing stop restarts the song from its first entry.
- tempo_div=0 -> each beat lasts 1 cycle, so a dur=3 note lasts 3 cycles. Assert rst_n low mid-note -> song_data=21 immediately, without waiting for a clock edge.
